data_path: RTL and testbench

Branch-focused SPARC V8 datapath slice: instruction register, PC/nPC pair, processor state register (integer condition codes), immediate extender, ALU with operand muxes, and the branch-logic evaluator (BLA) that decides whether a Bicc instruction is taken. It sits under the control unit, which drives every enable, clear and select below. The register file, RAM, MDR/MAR, TBR and TEMP are outside this block.

---
 rtl/data_path.sv | 185 ++++++++++++++++++
 tb/tb_data_path.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/data_path.sv
// SPARC V8 branch-focused datapath slice: IR, PC/nPC, PSR icc, immediate extender, ALU, branch evaluator.
// Optional DATAPATH_ANNUL_EN adds the 'annul' output for delay-slot annulment.
module data_path (
  input  logic        Clk,
  input  logic        RESET,
  input  logic        IR_Enable,
  input  logic [31:0] IR_In,
  output logic [31:0] IR_Out,
  input  logic        PC_enable,
  input  logic        PC_Clr,
  input  logic        NPC_enable,
  input  logic        NPC_Clr,
  input  logic        PSR_Enable,
  input  logic        PSR_Clr,
  output logic [31:0] PSR_out,
  input  logic [5:0]  ALU_op,
  output logic [31:0] ALU_Out,
  input  logic [2:0]  extender_select,
  output logic [31:0] extender_out,
  input  logic [1:0]  ALUA_Mux_select,
  output logic [31:0] ALUA_Mux_out,
  input  logic [2:0]  ALUB_Mux_select,
  output logic [31:0] ALUB_Mux_out,
  input  logic [1:0]  PC_In_Mux_select,
  output logic        out_BLA,
  output logic        BA_O,
  output logic        BN_O
`ifdef DATAPATH_ANNUL_EN
  ,
  output logic        annul
`endif
);

  localparam int unsigned DW      = 32;
  localparam int unsigned ICC_LSB = 20;

  logic [DW-1:0] ir_q, ir_d;
  logic [DW-1:0] pc_q, pc_d;
  logic [DW-1:0] npc_q, npc_d;
  logic [DW-1:0] psr_q, psr_d;
  logic [DW-1:0] pc_in_mux;
  logic          flag_n, flag_z, flag_v, flag_c;
  logic          icc_n, icc_z, icc_v, icc_c;
  logic          is_bicc, cond_val;
  logic [3:0]    cond;

  // Next-state with clear-over-enable priority; RESET handled in the register process
  always_comb begin
    ir_d  = ir_q;
    pc_d  = pc_q;
    npc_d = npc_q;
    psr_d = psr_q;
    if (IR_Enable) ir_d = IR_In;
    if (PC_Clr)          pc_d = '0;
    else if (PC_enable)  pc_d = pc_in_mux;
    if (NPC_Clr)         npc_d = '0;
    else if (NPC_enable) npc_d = ALU_Out;
    if (PSR_Clr) psr_d = '0;
    else if (PSR_Enable && ALU_op[4])
      psr_d[ICC_LSB+3:ICC_LSB] = {flag_n, flag_z, flag_v, flag_c};
  end

  always_ff @(posedge Clk) begin
    if (RESET) begin
      ir_q  <= '0;
      pc_q  <= '0;
      npc_q <= '0;
      psr_q <= '0;
    end else begin
      ir_q  <= ir_d;
      pc_q  <= pc_d;
      npc_q <= npc_d;
      psr_q <= psr_d;
    end
  end

  assign IR_Out  = ir_q;
  assign PSR_out = psr_q;
  assign {icc_n, icc_z, icc_v, icc_c} = psr_q[ICC_LSB+3:ICC_LSB];

  always_comb begin
    pc_in_mux = npc_q;
    case (PC_In_Mux_select)
      2'b01:   pc_in_mux = ALU_Out;
      2'b10:   pc_in_mux = '0;
      default: pc_in_mux = npc_q;
    endcase
  end

  always_comb begin
    extender_out = '0;
    case (extender_select)
      3'b000:  extender_out = {{8{ir_q[21]}}, ir_q[21:0], 2'b00};
      3'b001:  extender_out = {{19{ir_q[12]}}, ir_q[12:0]};
      3'b010:  extender_out = {ir_q[21:0], 10'b0};
      3'b011:  extender_out = {ir_q[29:0], 2'b00};
      default: extender_out = '0;
    endcase
  end

  always_comb begin
    ALUA_Mux_out = '0;
    case (ALUA_Mux_select)
      2'b01:   ALUA_Mux_out = pc_q;
      2'b10:   ALUA_Mux_out = npc_q;
      default: ALUA_Mux_out = '0;
    endcase
  end

  always_comb begin
    ALUB_Mux_out = '0;
    case (ALUB_Mux_select)
      3'b001:  ALUB_Mux_out = extender_out;
      3'b110:  ALUB_Mux_out = DW'(4);
      default: ALUB_Mux_out = '0;
    endcase
  end

  // ALU: op[4] selects the cc-setting variant, which shares the result of op[3:0]
  always_comb begin
    logic [DW:0] ext_res;
    logic [DW-1:0] a, b;
    logic cin;
    a       = ALUA_Mux_out;
    b       = ALUB_Mux_out;
    cin     = icc_c;
    ext_res = '0;
    ALU_Out = '0;
    flag_v  = 1'b0;
    flag_c  = 1'b0;
    if (!ALU_op[5]) begin
      case (ALU_op[3:0])
        4'b0000, 4'b1000: begin
          ext_res = {1'b0, a} + {1'b0, b} + (DW+1)'(ALU_op[3] & cin);
          ALU_Out = ext_res[DW-1:0];
          flag_c  = ext_res[DW];
          flag_v  = (a[DW-1] == b[DW-1]) && (ALU_Out[DW-1] != a[DW-1]);
        end
        4'b0100, 4'b1100: begin
          ext_res = {1'b0, a} - {1'b0, b} - (DW+1)'(ALU_op[3] & cin);
          ALU_Out = ext_res[DW-1:0];
          flag_c  = ext_res[DW];
          flag_v  = (a[DW-1] != b[DW-1]) && (ALU_Out[DW-1] != a[DW-1]);
        end
        4'b0001: ALU_Out = a & b;
        4'b0010: ALU_Out = a | b;
        4'b0011: ALU_Out = a ^ b;
        4'b0101: ALU_Out = a & ~b;
        4'b0110: ALU_Out = a | ~b;
        4'b0111: ALU_Out = ~(a ^ b);
        default: ALU_Out = '0;
      endcase
    end
    flag_n = ALU_Out[DW-1];
    flag_z = (ALU_Out == '0);
  end

  // Branch evaluator works on the registered icc, so a same-cycle cc update is not seen
  assign is_bicc = (ir_q[31:30] == 2'b00) && (ir_q[24:22] == 3'b010);
  assign cond    = ir_q[28:25];

  always_comb begin
    cond_val = 1'b0;
    case (cond[2:0])
      3'b000:  cond_val = 1'b0;
      3'b001:  cond_val = icc_z;
      3'b010:  cond_val = icc_z | (icc_n ^ icc_v);
      3'b011:  cond_val = icc_n ^ icc_v;
      3'b100:  cond_val = icc_c | icc_z;
      3'b101:  cond_val = icc_c;
      3'b110:  cond_val = icc_n;
      default: cond_val = icc_v;
    endcase
    if (cond[3]) cond_val = ~cond_val;
  end

  assign out_BLA = is_bicc & cond_val;
  assign BA_O    = is_bicc & (cond == 4'b1000);
  assign BN_O    = is_bicc & (cond == 4'b0000);

`ifdef DATAPATH_ANNUL_EN
  assign annul = is_bicc & ir_q[29] & (~out_BLA | BA_O);
`endif

endmodule

// File: tb/tb_data_path.sv
// Directed self-checking bench for data_path: reset, PC/nPC sequencing, extender, ALU, PSR icc, branch evaluation.
module tb_data_path;

  logic        Clk = 1'b0;
  logic        RESET;
  logic        IR_Enable;
  logic [31:0] IR_In;
  logic [31:0] IR_Out;
  logic        PC_enable, PC_Clr, NPC_enable, NPC_Clr, PSR_Enable, PSR_Clr;
  logic [31:0] PSR_out;
  logic [5:0]  ALU_op;
  logic [31:0] ALU_Out;
  logic [2:0]  extender_select;
  logic [31:0] extender_out;
  logic [1:0]  ALUA_Mux_select;
  logic [31:0] ALUA_Mux_out;
  logic [2:0]  ALUB_Mux_select;
  logic [31:0] ALUB_Mux_out;
  logic [1:0]  PC_In_Mux_select;
  logic        out_BLA, BA_O, BN_O;
`ifdef DATAPATH_ANNUL_EN
  logic        annul;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  data_path dut (
    .Clk(Clk), .RESET(RESET),
    .IR_Enable(IR_Enable), .IR_In(IR_In), .IR_Out(IR_Out),
    .PC_enable(PC_enable), .PC_Clr(PC_Clr),
    .NPC_enable(NPC_enable), .NPC_Clr(NPC_Clr),
    .PSR_Enable(PSR_Enable), .PSR_Clr(PSR_Clr), .PSR_out(PSR_out),
    .ALU_op(ALU_op), .ALU_Out(ALU_Out),
    .extender_select(extender_select), .extender_out(extender_out),
    .ALUA_Mux_select(ALUA_Mux_select), .ALUA_Mux_out(ALUA_Mux_out),
    .ALUB_Mux_select(ALUB_Mux_select), .ALUB_Mux_out(ALUB_Mux_out),
    .PC_In_Mux_select(PC_In_Mux_select),
    .out_BLA(out_BLA), .BA_O(BA_O), .BN_O(BN_O)
`ifdef DATAPATH_ANNUL_EN
    , .annul(annul)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic load_ir(input logic [31:0] w);
    IR_In = w;
    IR_Enable = 1'b1;
    tick();
    IR_Enable = 1'b0;
    #1;
  endtask

  task automatic check_bla(input string tag, input logic bla, input logic ba, input logic bn);
    check({tag, "_bla"}, 32'(out_BLA), 32'(bla));
    check({tag, "_ba"},  32'(BA_O),    32'(ba));
    check({tag, "_bn"},  32'(BN_O),    32'(bn));
  endtask

  initial begin
    RESET = 1'b1; IR_Enable = 1'b0; IR_In = '0;
    PC_enable = 1'b0; PC_Clr = 1'b0; NPC_enable = 1'b0; NPC_Clr = 1'b0;
    PSR_Enable = 1'b0; PSR_Clr = 1'b0; ALU_op = '0; extender_select = '0;
    ALUA_Mux_select = '0; ALUB_Mux_select = '0; PC_In_Mux_select = '0;
    tick();
    RESET = 1'b0;
    #1;
    check("rst_ir", IR_Out, 32'h0);
    check("rst_psr", PSR_out, 32'h0);
    check_bla("rst", 1'b0, 1'b0, 1'b0);
    ALUA_Mux_select = 2'b01; #1;
    check("rst_pc", ALUA_Mux_out, 32'h0);
    ALUA_Mux_select = 2'b10; #1;
    check("rst_npc", ALUA_Mux_out, 32'h0);

    // PC = 0 via ALU, then nPC = PC + 4
    PC_In_Mux_select = 2'b01; ALUA_Mux_select = 2'b00; ALUB_Mux_select = 3'b000; ALU_op = 6'b000000;
    PC_enable = 1'b1; tick(); PC_enable = 1'b0;
    ALUA_Mux_select = 2'b01; #1;
    check("init_pc", ALUA_Mux_out, 32'h0);
    ALUB_Mux_select = 3'b110; #1;
    check("alu_pc_plus4", ALU_Out, 32'h4);
    NPC_enable = 1'b1; tick(); NPC_enable = 1'b0;
    ALUA_Mux_select = 2'b10; #1;
    check("init_npc", ALUA_Mux_out, 32'h4);

    // addcc 0+0 sets Z only
    ALUA_Mux_select = 2'b00; ALUB_Mux_select = 3'b000; ALU_op = 6'b010000;
    PSR_Enable = 1'b1; tick(); PSR_Enable = 1'b0; #1;
    check("psr_z", PSR_out, 32'h0040_0000);

    load_ir(32'h0080_0000); check_bla("bn", 1'b0, 1'b0, 1'b1);
    load_ir(32'h1080_0000); check_bla("ba", 1'b1, 1'b1, 1'b0);
    load_ir(32'h3080_0000); check_bla("ba_a", 1'b1, 1'b1, 1'b0);
`ifdef DATAPATH_ANNUL_EN
    check("annul_ba_a", 32'(annul), 32'h1);
`endif
    load_ir(32'h0480_0000); check_bla("ble_z", 1'b1, 1'b0, 1'b0);
    load_ir(32'h0A80_0000); check_bla("bcs_z", 1'b0, 1'b0, 1'b0);
    load_ir(32'h1000_0000); check_bla("non_bicc", 1'b0, 1'b0, 1'b0);
    IR_In = 32'hDEAD_BEEF; tick(); #1;
    check("ir_hold", IR_Out, 32'h1000_0000);

    // PC <- nPC (4), then branch target PC + disp22*4
    PC_In_Mux_select = 2'b00; PC_enable = 1'b1; tick(); PC_enable = 1'b0;
    ALUA_Mux_select = 2'b01; #1;
    check("pc_from_npc", ALUA_Mux_out, 32'h4);
    load_ir(32'h0080_0003);
    extender_select = 3'b000; ALUB_Mux_select = 3'b001; ALU_op = 6'b000000; #1;
    check("ext_disp22", extender_out, 32'd12);
    check("alub_ext", ALUB_Mux_out, 32'd12);
    check("alu_target", ALU_Out, 32'd16);
    PC_In_Mux_select = 2'b01; PC_enable = 1'b1; tick(); PC_enable = 1'b0; #1;
    check("pc_target", ALUA_Mux_out, 32'd16);
    extender_select = 3'b010; #1;
    check("ext_imm22", extender_out, 32'h0000_0C00);
    extender_select = 3'b011; #1;
    check("ext_disp30", extender_out, 32'h0200_000C);
    extender_select = 3'b100; #1;
    check("ext_other", extender_out, 32'h0);
    load_ir(32'h00BF_FFFF);
    extender_select = 3'b000; #1;
    check("ext_disp22_neg", extender_out, 32'hFFFF_FFFC);
    load_ir(32'h0000_1FFF);
    extender_select = 3'b001; #1;
    check("ext_simm13_neg", extender_out, 32'hFFFF_FFFF);

    // subcc 0 - 4: N=1 Z=0 V=0 C=1
    ALUA_Mux_select = 2'b00; ALUB_Mux_select = 3'b110; ALU_op = 6'b010100; #1;
    check("alu_subcc", ALU_Out, 32'hFFFF_FFFC);
    PSR_Enable = 1'b1; tick(); PSR_Enable = 1'b0; #1;
    check("psr_subcc", PSR_out, 32'h0090_0000);
    load_ir(32'h0680_0000); check_bla("bl_neg", 1'b1, 1'b0, 1'b0);
    load_ir(32'h0A80_0000); check_bla("bcs_c", 1'b1, 1'b0, 1'b0);
    ALU_op = 6'b000000; PSR_Enable = 1'b1; tick(); PSR_Enable = 1'b0; #1;
    check("psr_hold_nocc", PSR_out, 32'h0090_0000);

    // carry-in ops use C=1
    ALU_op = 6'b001000; #1; check("alu_addx", ALU_Out, 32'h5);
    ALU_op = 6'b001100; #1; check("alu_subx", ALU_Out, 32'hFFFF_FFFB);

    // logic ops with A = PC (16), B = 4
    ALUA_Mux_select = 2'b01;
    ALU_op = 6'b000001; #1; check("alu_and",  ALU_Out, 32'h0);
    ALU_op = 6'b000010; #1; check("alu_or",   ALU_Out, 32'h14);
    ALU_op = 6'b000011; #1; check("alu_xor",  ALU_Out, 32'h14);
    ALU_op = 6'b000101; #1; check("alu_andn", ALU_Out, 32'h10);
    ALU_op = 6'b000110; #1; check("alu_orn",  ALU_Out, 32'hFFFF_FFFB);
    ALU_op = 6'b000111; #1; check("alu_xnor", ALU_Out, 32'hFFFF_FFEB);
    ALU_op = 6'b001001; #1; check("alu_unlisted", ALU_Out, 32'h0);
    ALU_op = 6'b100000; #1; check("alu_op5", ALU_Out, 32'h0);

    // clear beats enable
    ALU_op = 6'b010100; ALUA_Mux_select = 2'b00;
    PC_Clr = 1'b1; PC_enable = 1'b1; NPC_Clr = 1'b1; NPC_enable = 1'b1;
    PSR_Clr = 1'b1; PSR_Enable = 1'b1;
    tick();
    PC_Clr = 1'b0; PC_enable = 1'b0; NPC_Clr = 1'b0; NPC_enable = 1'b0;
    PSR_Clr = 1'b0; PSR_Enable = 1'b0;
    ALUA_Mux_select = 2'b01; #1;
    check("pc_clr", ALUA_Mux_out, 32'h0);
    ALUA_Mux_select = 2'b10; #1;
    check("npc_clr", ALUA_Mux_out, 32'h0);
    check("psr_clr", PSR_out, 32'h0);
    load_ir(32'h0480_0000); check_bla("ble_clear", 1'b0, 1'b0, 1'b0);
`ifdef DATAPATH_ANNUL_EN
    load_ir(32'h2480_0000);
    check("annul_untaken", 32'(annul), 32'h1);
`endif

    // PC source select 10 forces zero
    ALUA_Mux_select = 2'b00; ALUB_Mux_select = 3'b110; ALU_op = 6'b000000;
    PC_In_Mux_select = 2'b01; PC_enable = 1'b1; tick();
    PC_In_Mux_select = 2'b10; tick(); PC_enable = 1'b0;
    ALUA_Mux_select = 2'b01; #1;
    check("pc_sel_zero", ALUA_Mux_out, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
